// File: rtl/adlib_pkg.sv
// adlib_pkg: shared constants for the AdLib host interface.
//   - OPL2 timer register indices (0x02, 0x03, 0x04)
//   - bit positions inside the timer control register (0x04)
//   - bit positions inside the status byte, plus a helper that packs it
package adlib_pkg;

  localparam logic [7:0] REG_TIMER1     = 8'h02;
  localparam logic [7:0] REG_TIMER2     = 8'h03;
  localparam logic [7:0] REG_TIMER_CTRL = 8'h04;

  // Timer control register bits
  localparam int CTL_IRQ_RESET = 7;
  localparam int CTL_MASK1     = 6;
  localparam int CTL_MASK2     = 5;
  localparam int CTL_START2    = 1;
  localparam int CTL_START1    = 0;

  // Status byte bits
  localparam int ST_IRQ   = 7;
  localparam int ST_FLAG1 = 6;
  localparam int ST_FLAG2 = 5;

  function automatic logic [7:0] status_byte(input logic f1, input logic f2);
    logic [7:0] s;
    s           = 8'h00;
    s[ST_IRQ]   = f1 | f2;
    s[ST_FLAG1] = f1;
    s[ST_FLAG2] = f2;
    return s;
  endfunction

endpackage

// File: rtl/adlib_timer.sv
// adlib_timer: one OPL2 8-bit up-counting timer with overflow flag.
// Ports:
//   clk, rst     clock, async active-high reset
//   i_preset     reload value (loaded on start 0->1 and on overflow)
//   i_start      run enable; 0 freezes the counter
//   i_mask       suppresses flag setting on overflow
//   i_tick       one-cycle count enable from the shared tick generator
//   i_clr        flag clear; wins over a simultaneous overflow
//   o_flag       sticky overflow flag
import adlib_pkg::*;

module adlib_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_preset,
  input  logic       i_start,
  input  logic       i_mask,
  input  logic       i_tick,
  input  logic       i_clr,
  output logic       o_flag
);

  logic       r_start_q;
  logic [7:0] r_cnt;
  logic       r_flag;

  logic w_load, w_run, w_ovf;

  // The load cycle takes priority over a tick, so a tick landing on the
  // start edge counts from the preset rather than from a stale value.
  assign w_load = i_start & ~r_start_q;
  assign w_run  = i_start & r_start_q & i_tick;
  assign w_ovf  = w_run & (r_cnt == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_cnt     <= 8'h00;
      r_flag    <= 1'b0;
    end else begin
      r_start_q <= i_start;
      if (w_load)     r_cnt <= i_preset;
      else if (w_run) r_cnt <= w_ovf ? i_preset : r_cnt + 8'd1;
      if (i_clr)                  r_flag <= 1'b0;
      else if (w_ovf & ~i_mask)   r_flag <= 1'b1;
    end
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/adlib_host_if.sv
// adlib_host_if: CPU-facing register front end of the AdLib (OPL2) synth.
// Decodes address/data port writes into a latched register index plus a
// one-cycle write strobe, runs the two OPL2 timers and serves the status
// byte on reads of the address port.
// Ports:
//   clk, rst          clock, async active-high reset
//   io_a0             0 = address/status port, 1 = data port
//   io_wr, io_rd      CPU strobes (level, synchronous to clk)
//   io_din / io_dout  CPU write data / registered read data
//   reg_addr          latched OPL register index
//   reg_data, reg_wr  register write data and one-cycle write strobe
//   irq               timer interrupt request
// Build option: define ADLIB_IRQ_EN to drive irq from status bit 7
// (one cycle delayed); otherwise irq is tied low.
import adlib_pkg::*;

module adlib_host_if #(
  parameter int TICK_DIV    = 4000,
  parameter int T2_PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_a0,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       reg_wr,
  output logic       irq
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // ---------------- CPU write decode ----------------
  logic       r_prev_wr;
  logic [7:0] r_reg_addr, r_reg_data, r_dout;
  logic       r_reg_wr;
  logic       w_wr_hit;

  assign w_wr_hit = io_wr & ~r_prev_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_wr  <= 1'b0;
      r_reg_addr <= 8'h00;
      r_reg_data <= 8'h00;
      r_reg_wr   <= 1'b0;
    end else begin
      r_prev_wr <= io_wr;
      r_reg_wr  <= w_wr_hit & io_a0;
      if (w_wr_hit & ~io_a0) r_reg_addr <= io_din;
      if (w_wr_hit &  io_a0) r_reg_data <= io_din;
    end
  end

  // ---------------- timer registers ----------------
  // Decoded from the strobe itself, like the operator register files.
  logic [7:0] r_t1_pre, r_t2_pre;
  logic       r_mask1, r_mask2, r_start1, r_start2;
  logic       w_clr;

  assign w_clr = r_reg_wr & (r_reg_addr == REG_TIMER_CTRL) & r_reg_data[CTL_IRQ_RESET];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t1_pre <= 8'h00;
      r_t2_pre <= 8'h00;
      r_mask1  <= 1'b0;
      r_mask2  <= 1'b0;
      r_start1 <= 1'b0;
      r_start2 <= 1'b0;
    end else if (r_reg_wr) begin
      case (r_reg_addr)
        REG_TIMER1: r_t1_pre <= r_reg_data;
        REG_TIMER2: r_t2_pre <= r_reg_data;
        REG_TIMER_CTRL: begin
          // IRQ reset form leaves masks and starts untouched
          if (!r_reg_data[CTL_IRQ_RESET]) begin
            r_mask1  <= r_reg_data[CTL_MASK1];
            r_mask2  <= r_reg_data[CTL_MASK2];
            r_start1 <= r_reg_data[CTL_START1];
            r_start2 <= r_reg_data[CTL_START2];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- tick generation (free-running) ----------------
  logic [DW-1:0] r_div;
  logic [1:0]    r_pre;
  logic          w_tick80, w_tick320;

  assign w_tick80  = (r_div == DW'(TICK_DIV - 1));
  assign w_tick320 = w_tick80 & (r_pre == 2'(T2_PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_pre <= 2'd0;
    end else begin
      r_div <= w_tick80 ? '0 : r_div + 1'b1;
      if (w_tick80) r_pre <= w_tick320 ? 2'd0 : r_pre + 2'd1;
    end
  end

  // ---------------- timers ----------------
  logic w_flag1, w_flag2;

  adlib_timer u_t1 (
    .clk(clk), .rst(rst), .i_preset(r_t1_pre), .i_start(r_start1),
    .i_mask(r_mask1), .i_tick(w_tick80), .i_clr(w_clr), .o_flag(w_flag1)
  );

  adlib_timer u_t2 (
    .clk(clk), .rst(rst), .i_preset(r_t2_pre), .i_start(r_start2),
    .i_mask(r_mask2), .i_tick(w_tick320), .i_clr(w_clr), .o_flag(w_flag2)
  );

  // ---------------- read path / irq ----------------
  logic [7:0] w_status;
  assign w_status = status_byte(w_flag1, w_flag2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_dout <= 8'h00;
    else if (io_rd) r_dout <= io_a0 ? 8'hFF : w_status;
  end

`ifdef ADLIB_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= w_status[ST_IRQ];
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign io_dout  = r_dout;
  assign reg_addr = r_reg_addr;
  assign reg_data = r_reg_data;
  assign reg_wr   = r_reg_wr;

endmodule

// File: tb/tb_adlib_host_if.sv
module tb_adlib_host_if;
  localparam int TD = 4;
  localparam int PS = 4;

  logic       clk = 1'b0, rst = 1'b0;
  logic       io_a0 = 1'b0, io_wr = 1'b0, io_rd = 1'b0;
  logic [7:0] io_din = 8'h00;
  logic [7:0] io_dout, reg_addr, reg_data;
  logic       reg_wr, irq;

  always #5 clk = ~clk;

  adlib_host_if #(.TICK_DIV(TD), .T2_PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .io_a0(io_a0), .io_wr(io_wr), .io_rd(io_rd),
    .io_din(io_din), .io_dout(io_dout), .reg_addr(reg_addr),
    .reg_data(reg_data), .reg_wr(reg_wr), .irq(irq)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef ADLIB_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  // Ticks come straight from the cycle number since reset; timer state is
  // kept as plain per-timer arrays.
  logic [7:0] m_addr, m_data, m_dout;
  logic       m_wr, m_irq, m_prev;
  logic [7:0] t_pre [2];
  logic [7:0] t_cnt [2];
  logic       f [2], mk [2], st [2], stq [2];
  int         m_cyc;

  initial forever begin
    logic [7:0] stat;
    logic       tk [2];
    logic       clr, hit;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_addr = 0; m_data = 0; m_dout = 0; m_wr = 0; m_irq = 0; m_prev = 0; m_cyc = 0;
      for (int i = 0; i < 2; i++) begin
        t_pre[i] = 0; t_cnt[i] = 0; f[i] = 0; mk[i] = 0; st[i] = 0; stq[i] = 0;
      end
    end else begin
      stat  = {f[0] | f[1], f[0], f[1], 5'b00000};
      tk[0] = (m_cyc % TD) == TD - 1;
      tk[1] = tk[0] && ((m_cyc / TD) % PS) == PS - 1;
      clr   = m_wr && m_addr == 8'h04 && m_data[7];
      for (int i = 0; i < 2; i++) begin
        if (clr) f[i] = 1'b0;
        else if (st[i] && stq[i] && tk[i] && t_cnt[i] == 8'hFF && !mk[i]) f[i] = 1'b1;
        if (st[i] && !stq[i])  t_cnt[i] = t_pre[i];
        else if (st[i] && tk[i]) t_cnt[i] = (t_cnt[i] == 8'hFF) ? t_pre[i] : t_cnt[i] + 8'd1;
        stq[i] = st[i];
      end
      if (m_wr) begin
        if (m_addr == 8'h02) t_pre[0] = m_data;
        if (m_addr == 8'h03) t_pre[1] = m_data;
        if (m_addr == 8'h04 && !m_data[7]) begin
          mk[0] = m_data[6]; mk[1] = m_data[5]; st[1] = m_data[1]; st[0] = m_data[0];
        end
      end
      if (io_rd) m_dout = io_a0 ? 8'hFF : stat;
      m_irq = IRQ_ON & stat[7];
      hit   = io_wr && !m_prev;
      m_wr  = hit && io_a0;
      if (hit && io_a0)  m_data = io_din;
      if (hit && !io_a0) m_addr = io_din;
      m_prev = io_wr;
      m_cyc++;
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (rst || m_cyc >= 0) begin
      chk("dout",  io_dout,  m_dout);
      chk("addr",  reg_addr, m_addr);
      chk("data",  reg_data, m_data);
      chk("wr",    {7'b0, reg_wr}, {7'b0, m_wr});
      chk("irq",   {7'b0, irq},    {7'b0, m_irq});
    end
  end

  // reg_wr pulse counter for the literal strobe checks
  int         pulses = 0;
  logic [7:0] last_pd = 8'h00;
  initial forever begin
    @(negedge clk);
    if (reg_wr) begin
      pulses++;
      last_pd = reg_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic a0, input logic [7:0] d, input int len);
    @(posedge clk); #1;
    io_a0 = a0; io_din = d; io_wr = 1'b1;
    repeat (len) begin @(posedge clk); #1; end
    io_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic a0, input int len);
    @(posedge clk); #1;
    io_a0 = a0; io_rd = 1'b1;
    repeat (len) begin @(posedge clk); #1; end
    io_rd = 1'b0;
  endtask

  initial begin
    int p0, n;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_dout", io_dout,  8'h00);
    chk("rst_wr",   {7'b0, reg_wr}, 8'h00);
    rst = 1'b0;

    // address then data write
    p0 = pulses;
    wr(1'b0, 8'h20, 1);
    chk("addr_20", reg_addr, 8'h20);
    chk("addr_nopulse", 8'(pulses - p0), 8'd0);
    wr(1'b1, 8'h41, 1);
    chk("data_pulse", 8'(pulses - p0), 8'd1);
    chk("data_41", last_pd, 8'h41);
    chk("addr_kept", reg_addr, 8'h20);

    // long strobe -> single pulse
    p0 = pulses;
    wr(1'b1, 8'h5A, 10);
    chk("long_one_pulse", 8'(pulses - p0), 8'd1);
    chk("long_data", last_pd, 8'h5A);

    // timer 1, preset 0xFE, start
    wr(1'b0, 8'h02, 1); wr(1'b1, 8'hFE, 1);
    wr(1'b0, 8'h04, 1); wr(1'b1, 8'h01, 1);
    io_a0 = 1'b0; io_rd = 1'b1;
    n = 0;
    while (n < 40 && io_dout != 8'hC0) begin @(posedge clk); #1; n++; end
    io_rd = 1'b0;
    chk("t1_status", io_dout, 8'hC0);
    chk("t1_latency", {7'b0, (n <= 12)}, 8'd1);
    @(posedge clk); #1;
    chk("t1_irq", {7'b0, irq}, {7'b0, IRQ_ON});

    // stop, clear, status empty
    wr(1'b1, 8'h00, 1); wr(1'b1, 8'h80, 1);
    rd(1'b0, 1);
    chk("clr_status", io_dout, 8'h00);
    rd(1'b1, 1);
    chk("data_port_rd", io_dout, 8'hFF);

    // clear landing on an overflow edge: clear wins
    wr(1'b0, 8'h02, 1); wr(1'b1, 8'hFF, 1);
    wr(1'b0, 8'h04, 1); wr(1'b1, 8'h01, 1);
    repeat (12) @(posedge clk);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (m_cyc % TD != 2 && n < 10);
    io_a0 = 1'b1; io_din = 8'h80; io_wr = 1'b1;
    @(posedge clk); #1;
    io_wr = 1'b0;
    @(posedge clk); #1;             // clear + overflow edge just passed
    io_a0 = 1'b0; io_rd = 1'b1;
    @(posedge clk); #1;
    io_rd = 1'b0;
    chk("clr_wins", io_dout, 8'h00);
    wr(1'b1, 8'h00, 1); wr(1'b1, 8'h80, 1);

    // masked timer 2 at preset 0xFF never reports
    wr(1'b0, 8'h03, 1); wr(1'b1, 8'hFF, 1);
    wr(1'b0, 8'h04, 1); wr(1'b1, 8'h22, 1);
    io_a0 = 1'b0; io_rd = 1'b1;
    repeat (80) begin
      @(posedge clk); #1;
      chk("mask2_bit5", {7'b0, io_dout[5]}, 8'd0);
    end
    io_rd = 1'b0;

    // randomized traffic
    repeat (300) begin
      int op;
      logic [7:0] a;
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: a = 8'h02;
        1: a = 8'h03;
        2: a = 8'h04;
        default: a = 8'($urandom);
      endcase
      if (op <= 2)      wr(1'b0, a, $urandom_range(1, 3));
      else if (op <= 6) wr(1'b1, 8'($urandom), $urandom_range(1, 3));
      else if (op <= 8) rd(1'($urandom), $urandom_range(1, 3));
      else begin @(posedge clk); #1; end
    end

    // reset in the middle of a data write
    @(posedge clk); #1;
    io_a0 = 1'b1; io_din = 8'h77; io_wr = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_wr",   {7'b0, reg_wr}, 8'd0);
    chk("rst_mid_data", reg_data, 8'h00);
    chk("rst_mid_addr", reg_addr, 8'h00);
    chk("rst_mid_dout", io_dout,  8'h00);
    chk("rst_mid_irq",  {7'b0, irq}, 8'd0);
    io_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    p0 = pulses;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_pulse", 8'(pulses - p0), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
